// File: rtl/btn_debounce_if.sv
// Button conditioner bus: raw pins in, conditioned level/pulse/long flags out.
//   raw   : asynchronous button pins, 1 = pressed (driven by the board side)
//   level : debounced button state
//   down  : one-cycle pulse on accepted press
//   up    : one-cycle pulse on accepted release
//   long  : high while held for at least the long-press time
// master = board/core side, slave = the debouncer.
interface btn_debounce_if #(
  parameter int unsigned NBTN = 5
);
  logic [NBTN-1:0] raw;
  logic [NBTN-1:0] level;
  logic [NBTN-1:0] down;
  logic [NBTN-1:0] up;
  logic [NBTN-1:0] long;

  modport master (output raw, input level, down, up, long);
  modport slave  (input raw, output level, down, up, long);
endinterface

// File: rtl/btn_debounce.sv
// Multi-channel push-button conditioner. Each channel synchronises its raw
// pin through two flops, accepts a new level only after DEBOUNCE_CYC
// consecutive differing synchronised samples, emits one-cycle press/release
// pulses, and raises a long-press flag after LONG_CYC cycles of accepted high.
// Ports:
//   clk : single clock domain (40 MHz pixel clock)
//   rst : synchronous, active-high reset
//   bus : btn_debounce_if.slave (raw in; level, down, up, long out, all registered)
module btn_debounce #(
  parameter int unsigned NBTN         = 5,
  parameter int unsigned DEBOUNCE_CYC = 400000,
  parameter int unsigned DBW          = 19,
  parameter int unsigned LONG_CYC     = 20000000,
  parameter int unsigned LGW          = 25
) (
  input  logic           clk,
  input  logic           rst,
  btn_debounce_if.slave  bus
);

  localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYC - 1);
  localparam logic [LGW-1:0] LG_LAST = LGW'(LONG_CYC - 1);

  // Registered per-channel state
  logic [NBTN-1:0] s1;
  logic [NBTN-1:0] s;
  logic [NBTN-1:0] level_r;
  logic [NBTN-1:0] down_r;
  logic [NBTN-1:0] up_r;
  logic [NBTN-1:0] long_r;
  logic [DBW-1:0]  dcnt [NBTN];
  logic [LGW-1:0]  hcnt [NBTN];

  // Next-state values
  logic [NBTN-1:0] level_n;
  logic [NBTN-1:0] down_n;
  logic [NBTN-1:0] up_n;
  logic [NBTN-1:0] long_n;
  logic [DBW-1:0]  dcnt_n [NBTN];
  logic [LGW-1:0]  hcnt_n [NBTN];

  // Debounce, edge pulses and long-press hold counter for every channel
  always_comb begin
    level_n = level_r;
    down_n  = '0;
    up_n    = '0;
    long_n  = long_r;
    dcnt_n  = dcnt;
    hcnt_n  = hcnt;
    for (int unsigned i = 0; i < NBTN; i++) begin
      // Count consecutive cycles the synchronised pin disagrees with level;
      // any agreement restarts the count.
      if (s[i] != level_r[i]) begin
        if (dcnt[i] == DB_LAST) begin
          level_n[i] = s[i];
          dcnt_n[i]  = '0;
          down_n[i]  = s[i];
          up_n[i]    = ~s[i];
        end else begin
          dcnt_n[i] = dcnt[i] + DBW'(1);
        end
      end else begin
        dcnt_n[i] = '0;
      end

      // Hold counter saturates at LONG_CYC-1; an accepted release clears it
      // together with long on the same edge as the up pulse.
      if (level_r[i]) begin
        if (hcnt[i] == LG_LAST) begin
          long_n[i] = 1'b1;
        end else begin
          hcnt_n[i] = hcnt[i] + LGW'(1);
        end
        if (up_n[i]) begin
          hcnt_n[i] = '0;
          long_n[i] = 1'b0;
        end
      end else begin
        hcnt_n[i] = '0;
      end
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      s1      <= '0;
      s       <= '0;
      level_r <= '0;
      down_r  <= '0;
      up_r    <= '0;
      long_r  <= '0;
      for (int unsigned i = 0; i < NBTN; i++) begin
        dcnt[i] <= '0;
        hcnt[i] <= '0;
      end
    end else begin
      s1      <= bus.raw;
      s       <= s1;
      level_r <= level_n;
      down_r  <= down_n;
      up_r    <= up_n;
      long_r  <= long_n;
      for (int unsigned i = 0; i < NBTN; i++) begin
        dcnt[i] <= dcnt_n[i];
        hcnt[i] <= hcnt_n[i];
      end
    end
  end

  assign bus.level = level_r;
  assign bus.down  = down_r;
  assign bus.up    = up_r;
  assign bus.long  = long_r;

endmodule

// File: tb/tb_btn_debounce.sv
// Self-checking bench for btn_debounce: directed scenarios plus randomized
// button activity, compared every cycle against a sample-window reference model.
module tb_btn_debounce;

  localparam int unsigned NBTN = 5;
  localparam int unsigned DB   = 4;
  localparam int unsigned LONG = 10;

  logic clk;
  logic rst;

  btn_debounce_if #(.NBTN(NBTN)) bus ();

  btn_debounce #(
    .NBTN(NBTN), .DEBOUNCE_CYC(DB), .DBW(3), .LONG_CYC(LONG), .LGW(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors;
  int miscompares;

  // Reference model: level flips once the last DB synchronised samples all
  // disagree with it; long is level held for at least LONG edges.
  logic [NBTN-1:0] m_s1, m_s, m_level, m_down, m_up, m_long;
  logic [NBTN-1:0] shist[$];
  int              age [NBTN];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got %0h, want %0h", tag, $time, obs, exp);
    end
  endtask

  task automatic model_step(input logic [NBTN-1:0] rv, input logic rv_rst);
    logic            acc;
    logic [NBTN-1:0] e;
    if (rv_rst) begin
      m_s1 = '0; m_s = '0; m_level = '0; m_down = '0; m_up = '0; m_long = '0;
      shist.delete();
      for (int i = 0; i < int'(NBTN); i++) age[i] = 0;
      return;
    end
    shist.push_back(m_s);
    if (shist.size() > int'(DB)) void'(shist.pop_front());
    for (int i = 0; i < int'(NBTN); i++) begin
      acc = (shist.size() == int'(DB));
      for (int j = 0; j < shist.size(); j++) begin
        e = shist[j];
        if (e[i] == m_level[i]) acc = 1'b0;
      end
      m_down[i] = acc & ~m_level[i];
      m_up[i]   = acc & m_level[i];
      if (acc) begin
        m_level[i] = ~m_level[i];
        age[i] = 0;
      end else if (m_level[i]) begin
        age[i]++;
      end
      m_long[i] = m_level[i] && (age[i] >= int'(LONG));
    end
    m_s  = m_s1;
    m_s1 = rv;
  endtask

  // One clock: drive inputs, advance the model, compare after the edge.
  task automatic tick(input logic [NBTN-1:0] rv, input logic rv_rst);
    bus.raw = rv;
    rst     = rv_rst;
    model_step(rv, rv_rst);
    @(posedge clk);
    @(negedge clk);
    check("level", 32'(bus.level), 32'(m_level));
    check("down",  32'(bus.down),  32'(m_down));
    check("up",    32'(bus.up),    32'(m_up));
    check("long",  32'(bus.long),  32'(m_long));
  endtask

  logic [NBTN-1:0] rv;
  int              cnt;
  int              pos;
  logic            seen_long;
  logic [NBTN-1:0] down_seen;

  initial begin
    vectors = 0;
    miscompares = 0;
    bus.raw = '0;
    rst = 1'b1;
    @(negedge clk);
    tick('0, 1'b1);
    tick('0, 1'b1);

    // Clean press on ch0, held
    for (int k = 0; k < 20; k++) begin
      tick(5'b00001, 1'b0);
      if (k == 4) check("s1_level_e4", 32'(bus.level[0]), 32'd0);
      if (k == 5) begin
        check("s1_level_e5", 32'(bus.level[0]), 32'd1);
        check("s1_down_e5",  32'(bus.down[0]),  32'd1);
      end
      if (k == 6)  check("s1_down_e6", 32'(bus.down[0]), 32'd0);
      if (k == 14) check("s1_long_e14", 32'(bus.long[0]), 32'd0);
      if (k == 15) check("s1_long_e15", 32'(bus.long[0]), 32'd1);
    end

    // Release from held state
    cnt = 0;
    for (int k = 0; k < 12; k++) begin
      tick('0, 1'b0);
      if (bus.up[0]) cnt++;
      if (k == 4) begin
        check("s3_level_e4", 32'(bus.level[0]), 32'd1);
        check("s3_long_e4",  32'(bus.long[0]),  32'd1);
      end
      if (k == 5) begin
        check("s3_up_e5",    32'(bus.up[0]),    32'd1);
        check("s3_level_e5", 32'(bus.level[0]), 32'd0);
        check("s3_long_e5",  32'(bus.long[0]),  32'd0);
      end
    end
    check("s3_up_count", 32'(cnt), 32'd1);

    // Bounce: 3 high, 1 low, 3 high, 1 low, then steady high from tick 8
    cnt = 0;
    pos = -1;
    for (int k = 0; k < 20; k++) begin
      tick((k == 3 || k == 7) ? 5'b00000 : 5'b00001, 1'b0);
      if (bus.down[0]) begin
        cnt++;
        pos = k;
      end
    end
    check("s2_down_count", 32'(cnt), 32'd1);
    check("s2_down_pos",   32'(pos), 32'd13);
    for (int k = 0; k < 10; k++) tick('0, 1'b0);

    // Short hold: 5 accepted-high cycles
    cnt = 0;
    pos = 0;
    seen_long = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick((k < 5) ? 5'b00001 : 5'b00000, 1'b0);
      if (bus.down[0]) cnt++;
      if (bus.up[0])   pos++;
      if (bus.long[0]) seen_long = 1'b1;
    end
    check("s4_down_count", 32'(cnt), 32'd1);
    check("s4_up_count",   32'(pos), 32'd1);
    check("s4_no_long",    32'(seen_long), 32'd0);

    // Simultaneous channels with a 2-cycle glitch on ch1
    cnt = 0;
    down_seen = '0;
    seen_long = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick((k < 2) ? 5'b10111 : 5'b10101, 1'b0);
      if (bus.down != '0) begin
        cnt++;
        down_seen = bus.down;
      end
      if (bus.level[1]) seen_long = 1'b1;
    end
    check("s5_down_cycles", 32'(cnt), 32'd1);
    check("s5_down_vec",    32'(down_seen), 32'h15);
    check("s5_level1_low",  32'(seen_long), 32'd0);

    // Reset mid-hold on ch2 (plus ch0/ch4 still held)
    for (int k = 0; k < 12; k++) tick(5'b10101, 1'b0);
    check("s6_long2_pre", 32'(bus.long[2]), 32'd1);
    tick(5'b10101, 1'b1);
    check("s6_rst_outputs", 32'({bus.level, bus.down, bus.up, bus.long}), 32'd0);
    for (int k = 0; k < 8; k++) begin
      tick(5'b10101, 1'b0);
      if (k == 0) check("s6_no_up", 32'(bus.up), 32'd0);
      if (k == 5) begin
        check("s6_level2_e6", 32'(bus.level[2]), 32'd1);
        check("s6_down2_e6",  32'(bus.down[2]),  32'd1);
      end
    end

    // Randomized activity: bouncy phase, then long-hold phase
    rv = '0;
    for (int ph = 0; ph < 2; ph++) begin
      for (int k = 0; k < 1500; k++) begin
        for (int i = 0; i < int'(NBTN); i++) begin
          if ($urandom_range(0, (ph == 0) ? 3 : 39) == 0) rv[i] = ~rv[i];
        end
        tick(rv, ($urandom_range(0, 399) == 0));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
